mem_arbiter: RTL and testbench

Sequential arbiter sharing one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the three-stage pipeline. Accepts one request at a time, issues it to memory with a ready/valid handshake, and routes the read response back to its owner. Also generates the pipeline stall. Data requests normally win, and a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between the
// instruction-fetch port and the data (load/store) port of the pipeline.
//
// One transaction is handled at a time. Data requests normally win. The
// streak counter forces a fetch once STARVE_LIMIT data grants have gone by
// while a fetch was waiting.
//
// Handshakes (all ports):
//   A requester raises *_req with its fields stable and holds them until
//   *_gnt pulses. It may drop or change the request only in the cycle after
//   that gnt. Toward memory, mem_req/mem_* are held until mem_ready=1 in the
//   same cycle (acceptance). Each accepted read returns exactly one mem_rvalid
//   pulse later, and only one transaction is ever outstanding.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   inst_req/inst_addr           fetch request in
//   inst_gnt/inst_rvalid/rdata   fetch accept pulse, read data
//   data_req/we/addr/wdata/be    load/store request in
//   data_gnt/data_rvalid/rdata   data accept pulse, load data
//   mem_req/we/addr/wdata/be     request to memory
//   mem_ready                    memory accepts the request this cycle
//   mem_rvalid/mem_rdata         memory read response
//   stall                        pipeline must hold
//   err                          sticky: a response arrived with no read outstanding
//   dbg_state, dbg_streak        current FSM state (0 IDLE, 1 REQ, 2 RWAIT) and streak
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        err,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_streak
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  logic        owner, owner_next;    // 1 = data port owns the memory, 0 = fetch
  logic [3:0]  streak, streak_next;
  logic        err_q, err_next;

  logic        req_fire;
  logic        write_done;
  logic        read_done;
  logic        arb_point;
  logic        data_cand;
  logic        win_inst;
  logic        win_data;

  assign req_fire   = (state == REQ) && mem_ready;
  assign write_done = req_fire && owner && data_we;
  assign read_done  = (state == RWAIT) && mem_rvalid;
  assign arb_point  = (state == IDLE) || write_done || read_done;

  // A store completes in the same cycle its gnt pulses, so the requester is
  // still (legitimately) holding data_req for it; that request must not be
  // arbitrated a second time.
  assign data_cand  = data_req && !write_done;
  assign win_inst   = inst_req && (!data_cand || (streak == LIMIT));
  assign win_data   = data_cand && !win_inst;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      streak <= 4'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      streak <= streak_next;
      err_q  <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    streak_next = streak;
    err_next    = err_q;

    case (state)
      IDLE:    state_next = IDLE;
      REQ:     if (req_fire && !write_done) state_next = RWAIT;
      RWAIT:   state_next = RWAIT;
      default: state_next = IDLE;
    endcase

    // Completion and new selection share a cycle, so a pending request goes
    // straight back to REQ without an idle bubble.
    if (arb_point) begin
      if (win_inst || win_data) begin
        state_next = REQ;
        owner_next = win_data;
      end else begin
        state_next = IDLE;
      end
    end

    if (req_fire && !owner) begin
      streak_next = 4'd0;
    end else if (req_fire && owner && inst_req && (streak < LIMIT)) begin
      streak_next = streak + 4'd1;
    end

    // A response with no read outstanding (including one that belonged to a
    // transaction cut off by reset) is dropped and flagged.
    if (mem_rvalid && (state != RWAIT)) begin
      err_next = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_be      = 4'd0;
    inst_gnt    = 1'b0;
    data_gnt    = 1'b0;
    inst_rvalid = 1'b0;
    data_rvalid = 1'b0;

    if (state == REQ) begin
      mem_req = 1'b1;
      if (owner) begin
        mem_we    = data_we;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_be    = data_be;
      end else begin
        mem_we    = 1'b0;
        mem_addr  = inst_addr;
        mem_wdata = 32'd0;
        mem_be    = 4'hF;
      end
      inst_gnt = mem_ready && !owner;
      data_gnt = mem_ready && owner;
    end

    if (state == RWAIT) begin
      inst_rvalid = mem_rvalid && !owner;
      data_rvalid = mem_rvalid && owner;
    end

    inst_rdata = mem_rdata;
    data_rdata = mem_rdata;
    stall      = (inst_req && !inst_gnt) || (data_req && !data_gnt) ||
                 ((state == RWAIT) && !mem_rvalid);
    err        = err_q;
    dbg_state  = state;
    dbg_streak = streak;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 1-cycle memory model
// and per-port expected-response queues.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_streak;

  int          checks;
  int          failures;
  logic        auto_mem;
  logic        i_pend_q;
  logic        d_pend_q;
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall), .err(err), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'hC0DE_0000) + 32'h17;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples whether memory accepts a read at the coming edge, then advances
  // one cycle and drives the 1-cycle response (when the model is enabled).
  task automatic next_cycle();
    logic        acc_rd;
    logic [31:0] a;
    #1;
    acc_rd = mem_req && mem_ready && !mem_we;
    a      = mem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      mem_rvalid = acc_rd;
      mem_rdata  = acc_rd ? mem_val(a) : 32'd0;
    end
  endtask

  // ---------------- scoreboard / protocol monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
    end else begin
      if (i_pend_q) chk("inst_req_held_until_gnt", 32'(inst_req), 32'd1);
      if (d_pend_q) chk("data_req_held_until_gnt", 32'(data_req), 32'd1);
      i_pend_q <= inst_req && !inst_gnt;
      d_pend_q <= data_req && !data_gnt;
      if (inst_rvalid || data_rvalid)
        chk("rvalid_exclusive", 32'(inst_rvalid && data_rvalid), 32'd0);
      if (inst_rvalid) begin
        chk("inst_resp_expected", 32'(inst_q.size() != 0), 32'd1);
        if (inst_q.size() != 0) chk("inst_rdata_order", inst_rdata, inst_q.pop_front());
      end
      if (data_rvalid) begin
        chk("data_resp_expected", 32'(data_q.size() != 0), 32'd1);
        if (data_q.size() != 0) chk("data_rdata_order", data_rdata, data_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int budget;
    logic upd_i, upd_d;

    checks = 0; failures = 0; auto_mem = 1'b1;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_we = 1'b0; data_addr = 32'd0; data_wdata = 32'd0; data_be = 4'd0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_streak", 32'(dbg_streak), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_gnts", 32'({inst_gnt, data_gnt}), 32'd0);
    chk("rst_rvalids", 32'({inst_rvalid, data_rvalid}), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // single fetch
    inst_req = 1'b1; inst_addr = 32'h100; inst_q.push_back(32'hDEADBEEF);
    #1;
    chk("fetch_c0_stall", 32'(stall), 32'd1);
    chk("fetch_c0_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    #1;
    chk("fetch_c1_mem_req", 32'(mem_req), 32'd1);
    chk("fetch_c1_addr", mem_addr, 32'h100);
    chk("fetch_c1_we", 32'(mem_we), 32'd0);
    chk("fetch_c1_be", 32'(mem_be), 32'hF);
    chk("fetch_c1_gnt", 32'(inst_gnt), 32'd1);
    next_cycle();
    inst_req = 1'b0;
    #1;
    chk("fetch_c2_state", 32'(dbg_state), 32'd2);
    chk("fetch_c2_rvalid", 32'(inst_rvalid), 32'd1);
    chk("fetch_c2_rdata", inst_rdata, 32'hDEADBEEF);
    chk("fetch_c2_data_rvalid", 32'(data_rvalid), 32'd0);
    chk("fetch_c2_stall", 32'(stall), 32'd0);
    next_cycle();
    #1;
    chk("fetch_c3_idle", 32'(dbg_state), 32'd0);

    // store
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h2000;
    data_wdata = 32'h12345678; data_be = 4'b0011;
    #1;
    next_cycle();
    #1;
    chk("store_mem_req", 32'(mem_req), 32'd1);
    chk("store_we", 32'(mem_we), 32'd1);
    chk("store_be", 32'(mem_be), 32'b0011);
    chk("store_addr", mem_addr, 32'h2000);
    chk("store_wdata", mem_wdata, 32'h12345678);
    chk("store_gnt", 32'(data_gnt), 32'd1);
    chk("store_inst_gnt", 32'(inst_gnt), 32'd0);
    next_cycle();
    data_req = 1'b0; data_we = 1'b0;
    #1;
    chk("store_done_idle", 32'(dbg_state), 32'd0);
    chk("store_no_rvalid", 32'(data_rvalid), 32'd0);
    chk("store_streak", 32'(dbg_streak), 32'd0);

    // backpressure load
    mem_ready = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000; data_be = 4'hF;
    data_q.push_back(mem_val(32'h3000));
    #1;
    next_cycle();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("bp_mem_req", 32'(mem_req), 32'd1);
      chk("bp_addr", mem_addr, 32'h3000);
      chk("bp_gnt", 32'(data_gnt), 32'd0);
      chk("bp_stall", 32'(stall), 32'd1);
      next_cycle();
    end
    mem_ready = 1'b1;
    #1;
    chk("bp_gnt_c6", 32'(data_gnt), 32'd1);
    next_cycle();
    data_req = 1'b0;
    #1;
    chk("bp_rvalid", 32'(data_rvalid), 32'd1);
    next_cycle();
    #1;
    chk("bp_data_q_empty", 32'(data_q.size()), 32'd0);

    // back-to-back fetches
    inst_req = 1'b1; inst_addr = 32'h0; inst_q.push_back(mem_val(32'h0));
    #1;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b2b_mem_req", 32'(mem_req), 32'd1);
      chk("b2b_addr", mem_addr, 32'(i * 4));
      chk("b2b_gnt", 32'(inst_gnt), 32'd1);
      next_cycle();
      if (i < 2) begin
        inst_addr = 32'((i + 1) * 4);
        inst_q.push_back(mem_val(inst_addr));
      end else begin
        inst_req = 1'b0;
      end
      #1;
      chk("b2b_rvalid", 32'(inst_rvalid), 32'd1);
      chk("b2b_rwait_mem_req", 32'(mem_req), 32'd0);
      next_cycle();
    end
    #1;
    chk("b2b_idle", 32'(dbg_state), 32'd0);
    chk("b2b_inst_q_empty", 32'(inst_q.size()), 32'd0);

    // contention: grant k is a fetch exactly when k%5 == 4
    inst_req = 1'b1; inst_addr = 32'h8000; inst_q.push_back(mem_val(32'h8000));
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h4000; data_q.push_back(mem_val(32'h4000));
    #1;
    chk("cont_idle_stall", 32'(stall), 32'd1);
    chk("cont_start_streak", 32'(dbg_streak), 32'd0);
    k = 0;
    budget = 100;
    while ((inst_req || data_req) && budget > 0) begin
      #1;
      upd_i = inst_gnt;
      upd_d = data_gnt;
      if (inst_gnt || data_gnt) begin
        chk("cont_order_is_inst", 32'(inst_gnt), 32'((k % 5) == 4));
        chk("cont_streak", 32'(dbg_streak), 32'(k % 5));
        k++;
      end
      next_cycle();
      budget--;
      if (upd_i) begin
        if (k >= 10) inst_req = 1'b0;
        else begin
          inst_addr = inst_addr + 32'd4;
          inst_q.push_back(mem_val(inst_addr));
        end
      end
      if (upd_d) begin
        if (k >= 10) data_req = 1'b0;
        else begin
          data_addr = data_addr + 32'd4;
          data_q.push_back(mem_val(data_addr));
        end
      end
    end
    chk("cont_no_timeout", 32'(budget > 0), 32'd1);
    chk("cont_grant_count", 32'(k), 32'd11);
    next_cycle();
    next_cycle();
    #1;
    chk("cont_idle", 32'(dbg_state), 32'd0);
    chk("cont_inst_q_empty", 32'(inst_q.size()), 32'd0);
    chk("cont_data_q_empty", 32'(data_q.size()), 32'd0);
    chk("cont_err", 32'(err), 32'd0);

    // reset in RWAIT, then a late response
    auto_mem = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h5000;
    #1;
    next_cycle();
    #1;
    chk("rw_gnt", 32'(data_gnt), 32'd1);
    next_cycle();
    data_req = 1'b0;
    #1;
    chk("rw_state_rwait", 32'(dbg_state), 32'd2);
    chk("rw_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1;
    chk("rw_after_reset_idle", 32'(dbg_state), 32'd0);
    chk("rw_stray_no_data_rvalid", 32'(data_rvalid), 32'd0);
    chk("rw_stray_no_inst_rvalid", 32'(inst_rvalid), 32'd0);
    chk("rw_err_not_yet", 32'(err), 32'd0);
    next_cycle();
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #1;
    chk("rw_err_set", 32'(err), 32'd1);
    repeat (3) next_cycle();
    #1;
    chk("rw_err_sticky", 32'(err), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rw_err_cleared", 32'(err), 32'd0);
    chk("rw_final_idle", 32'(dbg_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
